alu_mul_sequencer: RTL and testbench

//  Multi-cycle unsigned multiply sequencer that drives the shared 32-bit ALU.

---
 rtl/alu_mul_sequencer.sv | 102 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU for one add per cycle.
// The full 2*WIDTH-bit product builds up in {hi, lo} while the multiplier bits shift out of lo.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= CALC;
                        mcand   <= a_in;
                        hi      <= '0;
                        lo      <= b_in;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                CALC: begin
                    // Carry, sum and the remaining multiplier bits shift right as one word.
                    {hi, lo} <= {alu_carry, alu_result, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state   <= DONE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign alu_req    = busy_r;
    assign product_hi = hi;
    assign product_lo = lo;
    assign alu_ctrl   = 3'b000;
    assign alu_a      = busy_r ? hi : '0;
    assign alu_b      = (busy_r && lo[0]) ? mcand : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random bench for alu_mul_sequencer with a behavioural 32-bit adder as the ALU.
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          ready, busy, done, alu_req, alu_carry;
    logic [W-1:0]  product_hi, product_lo, alu_a, alu_b, alu_result;
    logic [2:0]    alu_ctrl;
    logic [W:0]    alu_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = alu_sum[W-1:0];
    assign alu_carry  = alu_sum[W];

    alu_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .ready(ready), .busy(busy), .done(done),
        .product_hi(product_hi), .product_lo(product_lo),
        .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle_checks();
        check("alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("alu_req_eq_busy", 64'(alu_req), 64'(busy));
    endtask

    // Called at posedge+1 with start already driven; returns edges from acceptance to done.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            cycle_checks();
        end
    endtask

    task automatic do_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int edges;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_after_accept"}, 64'(busy), 64'd1);
        wait_done(edges);
        check({name, " latency"}, 64'(edges + 1), 64'd33);
        check({name, " product_hi"}, 64'(product_hi), 64'(eh));
        check({name, " product_lo"}, 64'(product_lo), 64'(el));
        check({name, " ready_in_done"}, 64'(ready), 64'd1);
        @(posedge clk); #1;
        check({name, " done_pulse_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int edges;
        logic [63:0] ref_p;
        logic [W-1:0] ra, rb;
        logic saw_done;

        vecs[0] = '{32'd3,        32'd5,        32'h0,        32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'h12345678, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{32'h0,        32'h9ABCDEF0, 32'h0,        32'h0};
        vecs[4] = '{32'h00010000, 32'h00010000, 32'h1,        32'h0};
        vecs[5] = '{32'h80000000, 32'd2,        32'h1,        32'h0};
        vecs[6] = '{32'd7,        32'd6,        32'h0,        32'h0000002A};
        vecs[7] = '{32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE};
        vecs[8] = '{32'h12345678, 32'h10,       32'h1,        32'h23456780};

        // Reset state
        #23;
        check("rst ready", 64'(ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst alu_req", 64'(alu_req), 64'd0);
        check("rst product", {product_hi, product_lo}, 64'd0);
        check("rst alu_a", 64'(alu_a), 64'd0);
        check("rst alu_b", 64'(alu_b), 64'd0);
        check("rst alu_ctrl", 64'(alu_ctrl), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle ready", 64'(ready), 64'd1);

        foreach (vecs[i])
            do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

        // Start held high through CALC with new operands, then back-to-back restart from DONE
        a_in  = 32'd3;
        b_in  = 32'd5;
        start = 1'b1;
        @(posedge clk); #1;
        a_in = 32'h0000DEAD;
        b_in = 32'h0000BEEF;
        wait_done(edges);
        check("hold latency", 64'(edges + 1), 64'd33);
        check("hold product", {product_hi, product_lo}, 64'd15);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b done_pulse_width", 64'(done), 64'd0);
        check("b2b busy", 64'(busy), 64'd1);
        wait_done(edges);
        check("b2b latency", 64'(edges + 1), 64'd33);
        ref_p = 64'(32'h0000DEAD) * 64'(32'h0000BEEF);
        check("b2b product", {product_hi, product_lo}, ref_p);
        @(posedge clk); #1;
        check("b2b idle done", 64'(done), 64'd0);

        // Asynchronous reset in the middle of CALC
        a_in  = 32'hFFFFFFFF;
        b_in  = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort ready", 64'(ready), 64'd1);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort alu_req", 64'(alu_req), 64'd0);
        check("abort product", {product_hi, product_lo}, 64'd0);
        check("abort alu_ab", {alu_a, alu_b}, 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", 64'(saw_done), 64'd0);
        do_mul("after_abort", 32'd7, 32'd6, 32'h0, 32'h2A);

        // Random operand pairs against a 64-bit reference product
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 50 == 0) ra = 32'hFFFFFFFF;
            if (k % 70 == 0) rb = 32'h80000000;
            ref_p = 64'(ra) * 64'(rb);
            do_mul($sformatf("rand%0d", k), ra, rb, ref_p[63:32], ref_p[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
